// File: rtl/dsp_core_pkg.sv
// Shared definitions for the DSP core, its memories and its bench:
// width defaults, instruction field positions, opcode encodings and
// TRUE/FALSE constants.
package dsp_core_pkg;

    localparam int DEF_SRAM_ADDR_LEN = 15;
    localparam int DEF_REG_WORD_LEN  = 16;
    localparam int DEF_MEM_ADDR_LEN  = 16;
    localparam int DEF_INST_WORD_LEN = 32;

    localparam int NUM_REGS = 8;

    // Instruction field positions
    localparam int OPC_LSB   = 28;
    localparam int RD_LSB    = 25;
    localparam int RS1_LSB   = 22;
    localparam int RS2_LSB   = 19;
    localparam int IMM_LEN   = 16;
    localparam int MADDR_LEN = 15;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LDI   = 4'd1,
        OP_LD1   = 4'd2,
        OP_LD2   = 4'd3,
        OP_ST2   = 4'd4,
        OP_ADD   = 4'd5,
        OP_SUB   = 4'd6,
        OP_MUL   = 4'd7,
        OP_MAC   = 4'd8,
        OP_MVA   = 4'd9,
        OP_CLA   = 4'd10,
        OP_JMP   = 4'd11,
        OP_BNZ   = 4'd12,
        OP_HALT  = 4'd13,
        OP_RES14 = 4'd14,
        OP_RES15 = 4'd15
    } opcode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } core_state_t;

endpackage

// File: rtl/dsp_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous
// write port, cleared by the asynchronous active-low reset.
module dsp_regfile
    import dsp_core_pkg::*;
#(
    parameter int WIDTH = DEF_REG_WORD_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       raddr_1,
    output logic [WIDTH-1:0] rdata_1,
    input  logic [2:0]       raddr_2,
    output logic [WIDTH-1:0] rdata_2
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    // Single write port; every register, r0 included, is writable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_1 = regs[raddr_1];
    assign rdata_2 = regs[raddr_2];

endmodule

// File: rtl/dsp_core.sv
// Single-cycle DSP core: the instruction at PC is decoded combinationally
// and committed on the next rising edge. Optional feature macro:
// DSP_MAC_EN adds a 32-bit signed accumulator (MAC/MVA/CLA); without it
// those opcodes behave as NOP.
module dsp_core
    import dsp_core_pkg::*;
#(
    parameter int SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
    parameter int REG_WORD_LEN  = DEF_REG_WORD_LEN,
    parameter int MEM_ADDR_LEN  = DEF_MEM_ADDR_LEN,
    parameter int INST_WORD_LEN = DEF_INST_WORD_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [SRAM_ADDR_LEN-1:0] read_addr_1,
    input  logic [REG_WORD_LEN-1:0]  read_data_1,
    output logic [SRAM_ADDR_LEN-1:0] read_addr_2,
    input  logic [REG_WORD_LEN-1:0]  read_data_2,
    output logic [SRAM_ADDR_LEN-1:0] write_addr_2,
    output logic [REG_WORD_LEN-1:0]  write_data_2,
    output logic                     write_en_2,
    output logic [MEM_ADDR_LEN-1:0]  read_addr_i,
    input  logic [INST_WORD_LEN-1:0] read_data_i
);

    localparam int PROD_LEN = 2 * REG_WORD_LEN;

    core_state_t               state;
    logic [MEM_ADDR_LEN-1:0]   pc;
    logic [MEM_ADDR_LEN-1:0]   next_pc;

    opcode_t                   opcode;
    logic [2:0]                rd;
    logic [2:0]                rs1;
    logic [2:0]                rs2;
    logic [IMM_LEN-1:0]        imm;
    logic [SRAM_ADDR_LEN-1:0]  mem_addr;

    logic [REG_WORD_LEN-1:0]   rs1_val;
    logic [REG_WORD_LEN-1:0]   rs2_val;
    logic                      rf_we;
    logic [REG_WORD_LEN-1:0]   rf_wdata;
    logic [PROD_LEN-1:0]       product;
    logic                      running;

    assign opcode   = opcode_t'(read_data_i[OPC_LSB +: 4]);
    assign rd       = read_data_i[RD_LSB +: 3];
    assign rs1      = read_data_i[RS1_LSB +: 3];
    assign rs2      = read_data_i[RS2_LSB +: 3];
    assign imm      = read_data_i[IMM_LEN-1:0];
    assign mem_addr = SRAM_ADDR_LEN'(imm[MADDR_LEN-1:0]);
    assign running  = (state == ST_RUN);

    assign read_addr_i  = pc;
    assign read_addr_1  = mem_addr;
    assign read_addr_2  = mem_addr;
    assign write_addr_2 = mem_addr;
    assign write_data_2 = rs1_val;
    // Store strobe is gated by reset so an aborted ST2 never reaches bank II
    assign write_en_2   = (opcode == OP_ST2) && running && rst;

    // Sign-extended operands: the low PROD_LEN bits equal the signed product
    assign product = {{REG_WORD_LEN{rs1_val[REG_WORD_LEN-1]}}, rs1_val}
                   * {{REG_WORD_LEN{rs2_val[REG_WORD_LEN-1]}}, rs2_val};

    dsp_regfile #(.WIDTH(REG_WORD_LEN)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata),
        .raddr_1 (rs1),
        .rdata_1 (rs1_val),
        .raddr_2 (rs2),
        .rdata_2 (rs2_val)
    );

`ifdef DSP_MAC_EN
    logic [PROD_LEN-1:0] acc;

    // Accumulator: MAC adds the signed product (wraps mod 2^32), CLA clears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (running) begin
            if (opcode == OP_MAC) begin
                acc <= acc + product;
            end else if (opcode == OP_CLA) begin
                acc <= '0;
            end
        end
    end
`endif

    // Register write-back select; nothing is written once halted
    always_comb begin
        rf_we    = FALSE;
        rf_wdata = '0;
        if (running) begin
            case (opcode)
                OP_LDI: begin rf_we = TRUE; rf_wdata = REG_WORD_LEN'(imm); end
                OP_LD1: begin rf_we = TRUE; rf_wdata = read_data_1; end
                OP_LD2: begin rf_we = TRUE; rf_wdata = read_data_2; end
                OP_ADD: begin rf_we = TRUE; rf_wdata = rs1_val + rs2_val; end
                OP_SUB: begin rf_we = TRUE; rf_wdata = rs1_val - rs2_val; end
                OP_MUL: begin rf_we = TRUE; rf_wdata = product[REG_WORD_LEN-1:0]; end
`ifdef DSP_MAC_EN
                OP_MVA: begin rf_we = TRUE; rf_wdata = acc[PROD_LEN-1:REG_WORD_LEN]; end
`endif
                default: begin rf_we = FALSE; rf_wdata = '0; end
            endcase
        end
    end

    // Next PC: sequential by default, imm for taken jumps, held on HALT
    always_comb begin
        next_pc = pc + MEM_ADDR_LEN'(1);
        case (opcode)
            OP_JMP:  next_pc = MEM_ADDR_LEN'(imm);
            OP_BNZ:  if (rs1_val != '0) next_pc = MEM_ADDR_LEN'(imm);
            OP_HALT: next_pc = pc;
            default: next_pc = pc + MEM_ADDR_LEN'(1);
        endcase
    end

    // Run/halt state and PC; HALT freezes everything until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            pc    <= '0;
        end else if (state == ST_RUN) begin
            pc <= next_pc;
            if (opcode == OP_HALT) begin
                state <= ST_HALT;
            end
        end
    end

    // Instruction bits 18:16 carry no field
`ifdef DSP_MAC_EN
    logic unused_bits;
    assign unused_bits = &{1'b0, read_data_i[RS2_LSB-1:IMM_LEN]};
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, read_data_i[RS2_LSB-1:IMM_LEN],
                           product[PROD_LEN-1:REG_WORD_LEN]};
`endif

endmodule

// File: tb/tb_dsp_core.sv
// Bench for dsp_core: bench-owned instruction memory and data banks, an
// instruction-level reference model, directed programs and random programs.
module tb_dsp_core;
    import dsp_core_pkg::*;

    logic        clk;
    logic        rst;
    logic [14:0] read_addr_1;
    logic [15:0] read_data_1;
    logic [14:0] read_addr_2;
    logic [15:0] read_data_2;
    logic [14:0] write_addr_2;
    logic [15:0] write_data_2;
    logic        write_en_2;
    logic [15:0] read_addr_i;
    logic [31:0] read_data_i;

    logic [31:0] imem  [0:65535];
    logic [15:0] bank1 [0:32767];
    logic [15:0] bank2 [0:32767];

    // reference model state
    logic [15:0] m_regs [8];
    logic [31:0] m_acc;
    logic [15:0] m_pc;
    logic        m_halted;
    logic [15:0] m_bank2 [0:32767];

    int n_checks;
    int n_errors;

    dsp_core dut (
        .clk          (clk),
        .rst          (rst),
        .read_addr_1  (read_addr_1),
        .read_data_1  (read_data_1),
        .read_addr_2  (read_addr_2),
        .read_data_2  (read_data_2),
        .write_addr_2 (write_addr_2),
        .write_data_2 (write_data_2),
        .write_en_2   (write_en_2),
        .read_addr_i  (read_addr_i),
        .read_data_i  (read_data_i)
    );

    // clock / memories
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data_i = imem[read_addr_i];
    assign read_data_1 = bank1[read_addr_1];
    assign read_data_2 = bank2[read_addr_2];

    always @(posedge clk) begin
        if (write_en_2) bank2[write_addr_2] <= write_data_2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input opcode_t op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        logic [2:0]  f_rd  = 3'(rd);
        logic [2:0]  f_rs1 = 3'(rs1);
        logic [2:0]  f_rs2 = 3'(rs2);
        logic [15:0] f_imm = 16'(imm);
        return {op, f_rd, f_rs1, f_rs2, 3'b000, f_imm};
    endfunction

    task automatic clear_imem();
        for (int a = 0; a < 65536; a++) imem[a] = enc(OP_NOP, 0, 0, 0, 0);
    endtask

    // store r0..r7 to bank II 100..107, then halt
    task automatic load_dump(input int base);
        for (int r = 0; r < 8; r++) imem[base + r] = enc(OP_ST2, 0, r, 0, 100 + r);
        imem[base + 8] = enc(OP_HALT, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_regs[r] = '0;
        m_acc    = '0;
        m_pc     = '0;
        m_halted = 1'b0;
    endtask

    // ISA-level interpretation of one instruction
    task automatic model_step();
        logic [31:0] ins;
        opcode_t     op;
        int          rd, s1, s2;
        logic [15:0] v1, v2, imm, nxt;
        ins = imem[m_pc];
        if (m_halted) return;
        op  = opcode_t'(ins[31:28]);
        rd  = int'(ins[27:25]);
        v1  = m_regs[ins[24:22]];
        v2  = m_regs[ins[21:19]];
        imm = ins[15:0];
        s1  = int'($signed(v1));
        s2  = int'($signed(v2));
        nxt = m_pc + 16'd1;
        case (op)
            OP_LDI: m_regs[rd] = imm;
            OP_LD1: m_regs[rd] = bank1[imm[14:0]];
            OP_LD2: m_regs[rd] = m_bank2[imm[14:0]];
            OP_ST2: m_bank2[imm[14:0]] = v1;
            OP_ADD: m_regs[rd] = v1 + v2;
            OP_SUB: m_regs[rd] = v1 - v2;
            OP_MUL: m_regs[rd] = 16'(s1 * s2);
`ifdef DSP_MAC_EN
            OP_MAC: m_acc = m_acc + 32'(s1 * s2);
            OP_MVA: m_regs[rd] = m_acc[31:16];
            OP_CLA: m_acc = '0;
`endif
            OP_JMP: nxt = imm;
            OP_BNZ: if (v1 != 16'd0) nxt = imm;
            OP_HALT: begin m_halted = 1'b1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // run n clocks from a falling edge, checking the visible behaviour each cycle
    task automatic run_cycles(input int n);
        logic [31:0] ins;
        logic        exp_we;
        for (int c = 0; c < n; c++) begin
            #1;
            ins    = imem[m_pc];
            exp_we = (ins[31:28] == OP_ST2) && !m_halted;
            check("pc", read_addr_i, m_pc);
            check("we", write_en_2, exp_we);
            if (exp_we) begin
                check("st_addr", write_addr_2, ins[14:0]);
                check("st_data", write_data_2, m_regs[ins[24:22]]);
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pc", read_addr_i, 0);
        check("rst_we", write_en_2, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n_prog;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        for (int a = 0; a < 32768; a++) begin
            bank1[a] = '0; bank2[a] = '0; m_bank2[a] = '0;
        end
        for (int a = 0; a < 16; a++) bank1[a] = 16'($urandom_range(0, 65535));
        bank1[0] = 16'd25;
        model_reset();

        // load from bank I, store to bank II, halt
        clear_imem();
        imem[0] = enc(OP_LD1, 0, 0, 0, 0);
        imem[1] = enc(OP_ST2, 0, 0, 0, 5);
        imem[2] = enc(OP_HALT, 0, 0, 0, 0);
        do_reset();
        run_cycles(3);
        #1;
        check("ld_st_bank2", bank2[5], 25);
        check("halt_pc", read_addr_i, 2);
        // a store placed at the halted PC must not fire
        imem[2] = enc(OP_ST2, 0, 0, 0, 9);
        run_cycles(3);
        check("halt_no_store", bank2[9], 0);

        // wrapping add / sub
        clear_imem();
        imem[0] = enc(OP_LDI, 1, 0, 0, 16'h7FFF);
        imem[1] = enc(OP_LDI, 2, 0, 0, 1);
        imem[2] = enc(OP_ADD, 3, 1, 2, 0);
        imem[3] = enc(OP_SUB, 4, 2, 2, 0);
        imem[4] = enc(OP_SUB, 6, 6, 2, 0);
        load_dump(5);
        do_reset();
        run_cycles(16);
        check("add_wrap", bank2[103], 16'h8000);
        check("sub_zero", bank2[104], 16'h0000);
        check("sub_under", bank2[106], 16'hFFFF);

        // counted loop with BNZ
        clear_imem();
        imem[0] = enc(OP_LDI, 2, 0, 0, 1);
        imem[1] = enc(OP_LDI, 1, 0, 0, 3);
        imem[2] = enc(OP_SUB, 1, 1, 2, 0);
        imem[3] = enc(OP_ADD, 3, 3, 2, 0);
        imem[4] = enc(OP_BNZ, 0, 1, 0, 2);
        load_dump(5);
        do_reset();
        run_cycles(25);
        check("loop_count", bank2[103], 3);
        check("loop_exit", bank2[101], 0);

        // multiply-accumulate
        clear_imem();
        imem[0] = enc(OP_LDI, 1, 0, 0, 16'h4000);
        imem[1] = enc(OP_LDI, 2, 0, 0, 4);
        imem[2] = enc(OP_MAC, 0, 1, 2, 0);
        imem[3] = enc(OP_MAC, 0, 1, 2, 0);
        imem[4] = enc(OP_MVA, 5, 0, 0, 0);
        imem[5] = enc(OP_MUL, 6, 1, 2, 0);
        load_dump(6);
        do_reset();
        run_cycles(20);
`ifdef DSP_MAC_EN
        check("mva", bank2[105], 16'h0002);
`else
        check("mva_nop", bank2[105], 16'h0000);
`endif
        check("mul_low", bank2[106], 16'h0000);

        // PC wrap from 0xFFFF to 0x0000
        clear_imem();
        imem[0]     = enc(OP_BNZ, 0, 1, 0, 6);
        imem[1]     = enc(OP_JMP, 0, 0, 0, 16'hFFFF);
        imem[16'hFFFF] = enc(OP_LDI, 1, 0, 0, 1);
        imem[6]     = enc(OP_HALT, 0, 0, 0, 0);
        do_reset();
        run_cycles(8);
        check("wrap_end_pc", read_addr_i, 6);

        // reset asserted during a store cycle
        clear_imem();
        imem[0] = enc(OP_ST2, 0, 3, 0, 200);
        imem[1] = enc(OP_LDI, 3, 0, 0, 16'h1234);
        imem[2] = enc(OP_ST2, 0, 3, 0, 201);
        imem[3] = enc(OP_HALT, 0, 0, 0, 0);
        do_reset();
        run_cycles(2);
        #1;
        check("st2_pending", write_en_2, 1);
        rst = 1'b0;
        #1;
        check("abort_we", write_en_2, 0);
        check("abort_pc", read_addr_i, 0);
        model_reset();
        @(negedge clk);
        check("abort_nowrite", bank2[201], 0);
        rst = 1'b1;
        run_cycles(6);
        check("rerun_r3_reset", bank2[200], 0);
        check("rerun_store", bank2[201], 16'h1234);

        // random programs
        n_prog = 8;
        for (int p = 0; p < n_prog; p++) begin
            clear_imem();
            for (int i = 0; i < 23; i++) begin
                int op, imm;
                op = int'($urandom_range(0, 15));
                if (op == 2 || op == 3 || op == 4) imm = int'($urandom_range(0, 15));
                else if (op == 11 || op == 12) imm = int'($urandom_range(0, 23));
                else imm = int'($urandom_range(0, 65535));
                imem[i] = enc(opcode_t'(op), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm);
            end
            imem[23] = enc(OP_HALT, 0, 0, 0, 0);
            do_reset();
            run_cycles(80);
        end

        // bank II contents against the model
        for (int a = 0; a < 256; a++) check("bank2", bank2[a], m_bank2[a]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dsp_core.md
DSP_CORE -- requirements
Module: dsp_core

Interface
REQ-001 Parameter SRAM_ADDR_LEN, default 15: data-bank address width.
REQ-002 Parameter REG_WORD_LEN, default 16: data word and register width.
REQ-003 Parameter MEM_ADDR_LEN, default 16: instruction address (PC) width.
REQ-004 Parameter INST_WORD_LEN, default 32: instruction word width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 read_addr_1  output  SRAM_ADDR_LEN  bank I read address (bank I is read-only to the core).
REQ-008 read_data_1  input  REG_WORD_LEN  bank I combinational read data.
REQ-009 read_addr_2  output  SRAM_ADDR_LEN  bank II read address.
REQ-010 read_data_2  input  REG_WORD_LEN  bank II combinational read data.
REQ-011 write_addr_2  output  SRAM_ADDR_LEN  bank II write address.
REQ-012 write_data_2  output  REG_WORD_LEN  bank II write data.
REQ-013 write_en_2  output  1  bank II write strobe, active-high.
REQ-014 read_addr_i  output  MEM_ADDR_LEN  instruction address (= PC).
REQ-015 read_data_i  input  INST_WORD_LEN  combinational instruction word.

Function
REQ-016 The core SHALL execute one instruction per clock, single-cycle, no pipeline: instruction at PC decoded and committed on the next rising edge.
REQ-017 Instruction fields SHALL be: [31:28] opcode, [27:25] rd, [24:22] rs1, [21:19] rs2, [15:0] imm; memory address = imm[14:0].
REQ-018 Register file SHALL be 8 x REG_WORD_LEN, two combinational reads, one synchronous write.
REQ-019 Opcodes SHALL be: 0 NOP; 1 LDI rd<=imm; 2 LD1 rd<=bank I[addr]; 3 LD2 rd<=bank II[addr]; 4 ST2 bank II[addr]<=rs1; 5 ADD rd<=rs1+rs2; 6 SUB rd<=rs1-rs2; 7 MUL rd<=low 16 bits of signed rs1*rs2; 8 MAC; 9 MVA; 10 CLA; 11 JMP PC<=imm; 12 BNZ if rs1!=0 PC<=imm; 13 HALT; 14-15 treated as NOP.
REQ-020 ADD/SUB SHALL wrap modulo 2^16 (0x7FFF+1 = 0x8000, 0x0000-1 = 0xFFFF); no flags.
REQ-021 read_addr_1, read_addr_2, write_addr_2 SHALL equal imm[14:0] combinationally; write_data_2 SHALL equal rs1 value.
REQ-022 write_en_2 SHALL be high combinationally only while opcode is ST2, core not halted, and rst deasserted.
REQ-023 Non-branch instructions SHALL set PC<=PC+1, wrapping 0xFFFF->0x0000; taken JMP/BNZ load imm.
REQ-024 HALT SHALL freeze PC, registers and accumulator until reset; write_en_2 held low while halted.
REQ-025 Register writes to any rd including r0 SHALL be allowed (no hard-wired zero).

Reset
REQ-026 While rst low: PC=0, all registers=0, accumulator=0, halted=0, write_en_2=0, independent of clk.
REQ-027 Reset asserted mid-program SHALL abort the current instruction with no write to bank II or registers; execution restarts at address 0 on the first rising edge after release.

Configuration
REQ-028 Macro DSP_MAC_EN: when defined, a 32-bit signed accumulator exists; MAC acc<=acc+signed(rs1*rs2) wrapping modulo 2^32; MVA rd<=acc[31:16]; CLA acc<=0.
REQ-029 Without DSP_MAC_EN, opcodes 8-10 SHALL behave as NOP (PC+1 only) and no accumulator is built.

Structure
REQ-030 Width defaults, opcode encodings, field positions and TRUE/FALSE constants SHALL live in the shared definitions package used by the memories and bench.
REQ-031 The register file SHALL be one sub-module, dsp_regfile; decode, ALU and PC stay in dsp_core.

Verification
REQ-032 Bank I[0]=25; program LD1 r0,0; ST2 r0,5; HALT -> after 3 clocks bank II[5]=25, write_en_2 pulsed once, PC frozen at 2.
REQ-033 LDI r1,0x7FFF; LDI r2,1; ADD r3,r1,r2; SUB r4,r2,r2 -> r3=0x8000, r4=0x0000.
REQ-034 LDI r1,3; SUB r1,r1,r2(r2=1) ; BNZ r1,1 -> loop body runs 3 times, then falls through to next address.
REQ-035 With DSP_MAC_EN: LDI r1,0x4000; LDI r2,4; MAC r1,r2 twice; MVA r5 -> r5=0x0002; without macro r5 unchanged (0).
REQ-036 Assert rst low during an ST2 cycle -> write_en_2 low immediately, PC=0, registers=0; program reruns correctly after release.
